// File: rtl/audio_i2s_receiver_pkg.sv
// Shared audio definitions: legal sample widths and the serial-framing FSM
// encoding used by both the I2S receiver and transmitter.
package audio_i2s_receiver_pkg;

    localparam int AUDIO_WIDTH_16      = 16;
    localparam int AUDIO_WIDTH_24      = 24;
    localparam int AUDIO_WIDTH_32      = 32;
    localparam int AUDIO_WIDTH_DEFAULT = AUDIO_WIDTH_24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } i2s_state_e;

    function automatic logic audio_width_legal(input int width);
        return (width == AUDIO_WIDTH_16) || (width == AUDIO_WIDTH_24) ||
               (width == AUDIO_WIDTH_32);
    endfunction

    // Bit counter must be able to hold the full word width itself.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/audio_i2s_receiver_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop that
// yields single-cycle rise/fall strobes in the sys_clk domain.
module sync_edge_det (
    input  logic sys_clk,
    input  logic reset,
    input  logic d_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, hist_q;
    logic meta_d, sync_d, hist_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~hist_q;
    assign fall     = ~sync_q & hist_q;

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S ADC receiver: oversamples BCLK/LRCK/DAT in the sys_clk domain, frames
// left/right words and presents complete stereo pairs with a valid pulse.
module audio_i2s_receiver #(
    parameter int AUDIO_WIDTH = 24
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   iAUD_BCLK,
    input  logic                   iAUD_ADCLRCK,
    input  logic                   iAUD_ADCDAT,
    output logic [AUDIO_WIDTH-1:0] o_lsound_in,
    output logic [AUDIO_WIDTH-1:0] o_rsound_in,
    output logic                   o_valid,
    output logic                   o_frame_err
);

    import audio_i2s_receiver_pkg::*;

    localparam int CNT_W = bit_cnt_width(AUDIO_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(AUDIO_WIDTH - 1);

    logic [2:0] pin_vec;
    logic [2:0] sync_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pin_vec = {iAUD_ADCDAT, iAUD_ADCLRCK, iAUD_BCLK};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge_det u_sync (
                .sys_clk  (sys_clk),
                .reset    (reset),
                .d_in     (pin_vec[gi]),
                .sync_out (sync_vec[gi]),
                .rise     (rise_vec[gi]),
                .fall     (fall_vec[gi])
            );
        end
    endgenerate

    logic bclk_rise, lrck_s, dat_s;
    assign bclk_rise = rise_vec[0];
    assign lrck_s    = sync_vec[1];
    assign dat_s     = sync_vec[2];

    logic unused_edges;
    assign unused_edges = ^{sync_vec[0], rise_vec[2:1], fall_vec};

    i2s_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AUDIO_WIDTH-1:0] shift_q, shift_d;
    logic [AUDIO_WIDTH-1:0] hold_q, hold_d;
    logic                   left_ok_q, left_ok_d;
    logic                   chan_q, chan_d;
    logic                   lrck_prev_q, lrck_prev_d;
    logic                   lrck_seen_q, lrck_seen_d;
    logic                   done_q, done_d;
    logic [AUDIO_WIDTH-1:0] lsound_q, lsound_d;
    logic [AUDIO_WIDTH-1:0] rsound_q, rsound_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   lrck_change;

    // The first BCLK edge after reset only primes the LRCK history, so a
    // release in the middle of a slot is not mistaken for a channel change.
    assign lrck_change = bclk_rise && lrck_seen_q && (lrck_s != lrck_prev_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        left_ok_d   = left_ok_q;
        chan_d      = chan_q;
        lrck_prev_d = lrck_prev_q;
        lrck_seen_d = lrck_seen_q;
        done_d      = 1'b0;
        lsound_d    = lsound_q;
        rsound_d    = rsound_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (bclk_rise) begin
            lrck_prev_d = lrck_s;
            lrck_seen_d = 1'b1;
        end

        // A word finished on the previous cycle; BCLK edges are at least four
        // cycles apart so shift_q is still intact here.
        if (done_q) begin
            if (!chan_q) begin
                hold_d    = shift_q;
                left_ok_d = 1'b1;
            end else if (left_ok_q) begin
                lsound_d  = hold_q;
                rsound_d  = shift_q;
                valid_d   = 1'b1;
                left_ok_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (lrck_change) begin
                    state_d = SKIP;
                    chan_d  = lrck_s;
                end
            end
            SKIP, SHIFT: begin
                if (lrck_change) begin
                    state_d   = SKIP;
                    chan_d    = lrck_s;
                    cnt_d     = '0;
                    shift_d   = '0;
                    left_ok_d = 1'b0;
                    err_d     = 1'b1;
                end else if (bclk_rise) begin
                    if (state_q == SKIP) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        shift_d = {shift_q[AUDIO_WIDTH-2:0], dat_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = WAIT;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (lrck_change) begin
                    state_d = SKIP;
                    chan_d  = lrck_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            left_ok_q   <= 1'b0;
            chan_q      <= 1'b0;
            lrck_prev_q <= 1'b0;
            lrck_seen_q <= 1'b0;
            done_q      <= 1'b0;
            lsound_q    <= '0;
            rsound_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            left_ok_q   <= left_ok_d;
            chan_q      <= chan_d;
            lrck_prev_q <= lrck_prev_d;
            lrck_seen_q <= lrck_seen_d;
            done_q      <= done_d;
            lsound_q    <= lsound_d;
            rsound_q    <= rsound_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_lsound_in = lsound_q;
    assign o_rsound_in = rsound_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Bench for audio_i2s_receiver: 24-bit and 16-bit instances share one serial
// stream; results are checked against a slot-level model and a directed table.
module tb_audio_i2s_receiver;

    typedef struct packed {
        logic lrck;
        logic dat;
    } bedge_t;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
        int          t;
    } pair_t;

    typedef struct {
        string       name;
        logic [31:0] l_word;
        logic [31:0] r_word;
        int          frames;
        int          prefix;
        int          trunc;
        int          slot;
        int          exp_valid;
        int          exp_err;
        logic [23:0] exp_l24;
        logic [23:0] exp_r24;
        logic [15:0] exp_l16;
        logic [15:0] exp_r16;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        bclk    = 1'b0;
    logic        lrck    = 1'b0;
    logic        dat     = 1'b0;
    logic [23:0] l24, r24;
    logic [15:0] l16, r16;
    logic        v24, e24, v16, e16;

    audio_i2s_receiver #(.AUDIO_WIDTH(24)) dut24 (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .iAUD_BCLK    (bclk),
        .iAUD_ADCLRCK (lrck),
        .iAUD_ADCDAT  (dat),
        .o_lsound_in  (l24),
        .o_rsound_in  (r24),
        .o_valid      (v24),
        .o_frame_err  (e24)
    );

    audio_i2s_receiver #(.AUDIO_WIDTH(16)) dut16 (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .iAUD_BCLK    (bclk),
        .iAUD_ADCLRCK (lrck),
        .iAUD_ADCDAT  (dat),
        .o_lsound_in  (l16),
        .o_rsound_in  (r16),
        .o_valid      (v16),
        .o_frame_err  (e16)
    );

    always #10 sys_clk = ~sys_clk;

    int     cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    bedge_t stim[$];
    int     rise_cyc[$];
    pair_t  got24[$], got16[$], exp_q[$];
    int     ferr24, ferr16, hold24, hold16, exp_errs;
    int     errors = 0;
    int     checks = 0;
    logic   prev_ok = 1'b0;
    logic [47:0] prev24;
    logic [31:0] prev16;
    vec_t   vecs[5];

    always @(negedge sys_clk) begin
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            if (v24) got24.push_back(pair_t'{32'(l24), 32'(r24), cyc});
            if (v16) got16.push_back(pair_t'{32'(l16), 32'(r16), cyc});
            if (e24) ferr24++;
            if (e16) ferr16++;
            if (prev_ok && !v24 && ({l24, r24} != prev24)) hold24++;
            if (prev_ok && !v16 && ({l16, r16} != prev16)) hold16++;
            prev_ok = 1'b1;
        end
        prev24 = {l24, r24};
        prev16 = {l16, r16};
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_slot(input logic ch, input logic [31:0] word, input int len);
        logic [31:0] w;
        bedge_t      e;
        w = word;
        for (int j = 0; j < len; j++) begin
            e.lrck = ch;
            e.dat  = (j >= 2 && j < 34) ? w[33-j] : 1'($urandom);
            stim.push_back(e);
        end
    endtask

    // Slot layout: change edge, one delay edge, then data MSB first.
    task automatic build_stream(input logic [31:0] l, input logic [31:0] r, input int frames,
                                input int prefix, input int trunc, input int slot);
        stim.delete();
        push_slot(1'b1, $urandom, prefix);
        for (int f = 0; f < frames; f++) begin
            push_slot(1'b0, l, (f == 0 && trunc >= 0) ? trunc + 2 : slot);
            push_slot(1'b1, r, slot);
        end
        push_slot(1'b0, $urandom, 10);
    endtask

    // Slot-level reference: a word is the w bits after the delay edge following
    // a channel change, unless the next change arrives before its last bit.
    task automatic model_run(input int w);
        int          ch[$];
        int          k, nxt, last;
        logic        left_ok;
        logic [31:0] hold, word;
        exp_q.delete();
        exp_errs = 0;
        left_ok  = 1'b0;
        hold     = '0;
        for (int i = 1; i < stim.size(); i++)
            if (stim[i].lrck != stim[i-1].lrck) ch.push_back(i);
        for (int c = 0; c < ch.size(); c++) begin
            k    = ch[c];
            last = k + 1 + w;
            nxt  = (c + 1 < ch.size()) ? ch[c+1] : stim.size() + 1000;
            if (nxt <= last) begin
                exp_errs++;
                left_ok = 1'b0;
            end else if (last < stim.size()) begin
                word = '0;
                for (int b = 0; b < w; b++) word = {word[30:0], stim[k+2+b].dat};
                if (!stim[k].lrck) begin
                    hold    = word;
                    left_ok = 1'b1;
                end else if (left_ok) begin
                    exp_q.push_back(pair_t'{hold, word, last});
                    left_ok = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_dut(input string tag, input int w);
        pair_t gq[$];
        int    fe, hv, n;
        model_run(w);
        if (w == 24) begin gq = got24; fe = ferr24; hv = hold24; end
        else         begin gq = got16; fe = ferr16; hv = hold16; end
        check({tag, "_valid_count"}, 64'(gq.size()), 64'(exp_q.size()));
        check({tag, "_frame_err_count"}, 64'(fe), 64'(exp_errs));
        check({tag, "_hold_violations"}, 64'(hv), 64'd0);
        n = (gq.size() < exp_q.size()) ? gq.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pair%0d", tag, i), {gq[i].l, gq[i].r}, {exp_q[i].l, exp_q[i].r});
            check($sformatf("%s_latency%0d", tag, i), 64'(gq[i].t - rise_cyc[exp_q[i].t]), 64'd4);
        end
    endtask

    task automatic run_case(input string name, input logic [31:0] l, input logic [31:0] r,
                            input int frames, input int prefix, input int trunc, input int slot,
                            input int hmin, input int hmax, input int vi);
        build_stream(l, r, frames, prefix, trunc, slot);
        reset = 1'b1;
        bclk  = 1'b0;
        wait_cyc(3);
        check({name, "_reset24"}, {l24, r24, v24, e24}, 64'd0);
        check({name, "_reset16"}, {l16, r16, v16, e16}, 64'd0);
        got24.delete();
        got16.delete();
        rise_cyc.delete();
        ferr24 = 0; ferr16 = 0; hold24 = 0; hold16 = 0;
        reset = 1'b0;
        wait_cyc(2);
        for (int i = 0; i < stim.size(); i++) begin
            bclk = 1'b0;
            lrck = stim[i].lrck;
            dat  = stim[i].dat;
            wait_cyc($urandom_range(hmin, hmax));
            bclk = 1'b1;
            rise_cyc.push_back(cyc);
            wait_cyc($urandom_range(hmin, hmax));
        end
        bclk = 1'b0;
        wait_cyc(16);
        compare_dut({name, "_w24"}, 24);
        compare_dut({name, "_w16"}, 16);
        if (vi >= 0) begin
            check({name, "_tbl_valid24"}, 64'(got24.size()), 64'(vecs[vi].exp_valid));
            check({name, "_tbl_valid16"}, 64'(got16.size()), 64'(vecs[vi].exp_valid));
            check({name, "_tbl_err24"}, 64'(ferr24), 64'(vecs[vi].exp_err));
            check({name, "_tbl_err16"}, 64'(ferr16), 64'(vecs[vi].exp_err));
            check({name, "_tbl_out24"}, {l24, r24}, {vecs[vi].exp_l24, vecs[vi].exp_r24});
            check({name, "_tbl_out16"}, {l16, r16}, {vecs[vi].exp_l16, vecs[vi].exp_r16});
        end
        $display("case %s: w24 valid=%0d frame_err=%0d | w16 valid=%0d frame_err=%0d",
                 name, got24.size(), ferr24, got16.size(), ferr16);
    endtask

    initial begin
        vecs[0] = '{"basic",   32'h12345600, 32'hABCDEF00, 3, 1,  -1, 32, 3, 0,
                    24'h123456, 24'hABCDEF, 16'h1234, 16'hABCD};
        vecs[1] = '{"extreme", 32'h80000000, 32'h7FFFFF00, 3, 1,  -1, 32, 3, 0,
                    24'h800000, 24'h7FFFFF, 16'h8000, 16'h7FFF};
        vecs[2] = '{"w16",     32'h80010000, 32'h00010000, 2, 1,  -1, 26, 2, 0,
                    24'h800100, 24'h000100, 16'h8001, 16'h0001};
        vecs[3] = '{"trunc10", 32'h0F0F0F00, 32'hF0F0F000, 3, 1,  10, 32, 2, 1,
                    24'h0F0F0F, 24'hF0F0F0, 16'h0F0F, 16'hF0F0};
        vecs[4] = '{"midslot", 32'h13579B00, 32'h2468AC00, 2, 13, -1, 32, 2, 0,
                    24'h13579B, 24'h2468AC, 16'h1357, 16'h2468};

        for (int v = 0; v < 5; v++)
            run_case(vecs[v].name, vecs[v].l_word, vecs[v].r_word, vecs[v].frames,
                     vecs[v].prefix, vecs[v].trunc, vecs[v].slot, 8, 8, v);

        for (int n = 0; n < 8; n++) begin
            int trunc;
            trunc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_case($sformatf("rand%0d", n), $urandom, $urandom,
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 20)), trunc,
                     ($urandom_range(0, 1) == 1) ? 32 : 26, 2, 8, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
